traffic_interval_timer: RTL and testbench

- Countdown timer on the far end of the controller's timer interface.
- The traffic light controller drives timer_load / timer_en / timer_init; this block returns timer_out.
- Divides the system clock into 1-second ticks and counts the loaded interval (0–15 s) down to 0, holding at 0.
- Also reports a one-cycle expiry pulse and the raw second tick, for the pedestrian/walk display logic.

---
 rtl/traffic_interval_timer_pkg.sv | 21 ++
 rtl/traffic_interval_timer_prescaler.sv | 39 +++
 rtl/traffic_interval_timer.sv | 86 ++++++++
 tb/tb_traffic_interval_timer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/traffic_interval_timer_pkg.sv
// Shared definitions for the traffic light controller and its interval timer:
// timer state encodings, light/pedestrian codes and timer widths.
package traffic_interval_timer_pkg;

  localparam int TIMER_W      = 4;
  localparam int TICK_DIV_SIM = 4;

  typedef enum logic [1:0] {
    TMR_IDLE  = 2'd0,
    TMR_ARMED = 2'd1,
    TMR_RUN   = 2'd2,
    TMR_DONE  = 2'd3
  } timer_state_e;

  localparam logic [1:0] LIGHT_RED     = 2'd0;
  localparam logic [1:0] LIGHT_GREEN   = 2'd1;
  localparam logic [1:0] LIGHT_YELLOW  = 2'd2;
  localparam logic       PED_DONT_WALK = 1'b0;
  localparam logic       PED_WALK      = 1'b1;

endpackage

// File: rtl/traffic_interval_timer_prescaler.sv
// Divides clk into second ticks; the count holds while disabled so a paused
// second resumes exactly where it stopped.
module tick_prescaler #(
  parameter int TICK_DIV = 100000000,
  parameter int PS_W     = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic wrap,
  output logic tick
);

  localparam logic [PS_W-1:0] LAST = PS_W'(TICK_DIV - 1);

  logic [PS_W-1:0] count_reg;
  logic            tick_reg;

  // wrap lets the owner decrement on the same edge the prescaler rolls over
  assign wrap = enable && (count_reg == LAST);
  assign tick = tick_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      tick_reg  <= 1'b0;
    end else if (clear) begin
      count_reg <= '0;
      tick_reg  <= 1'b0;
    end else begin
      tick_reg <= wrap;
      if (enable) begin
        count_reg <= wrap ? '0 : count_reg + PS_W'(1);
      end
    end
  end

endmodule

// File: rtl/traffic_interval_timer.sv
// Interval timer for the traffic light controller: loads a 0-15 s interval,
// counts it down once per second tick and flags expiry when it reaches 0.
module traffic_interval_timer
  import traffic_interval_timer_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int PS_W     = 27
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timer_load,
  input  logic               timer_en,
  input  logic [TIMER_W-1:0] timer_init,
  output logic [TIMER_W-1:0] timer_out,
  output logic               timer_expired,
  output logic               sec_tick
);

  timer_state_e       state_reg, state_next;
  logic [TIMER_W-1:0] out_reg, out_next;
  logic               expired_reg, expired_next;
  logic               count_en;
  logic               wrap;

  // ARMED counts too, so the first enabled cycle is already a counted cycle
  assign count_en = !timer_load && timer_en &&
                    ((state_reg == TMR_ARMED) || (state_reg == TMR_RUN));

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .PS_W     (PS_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_load),
    .enable (count_en),
    .wrap   (wrap),
    .tick   (sec_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= TMR_IDLE;
      out_reg     <= '0;
      expired_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      out_reg     <= out_next;
      expired_reg <= expired_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    out_next     = out_reg;
    expired_next = 1'b0;
    if (timer_load) begin
      out_next   = timer_init;
      state_next = (timer_init != '0) ? TMR_ARMED : TMR_DONE;
    end else begin
      case (state_reg)
        TMR_ARMED, TMR_RUN: begin
          if (timer_en) begin
            state_next = TMR_RUN;
            if (wrap) begin
              out_next = out_reg - TIMER_W'(1);
              if (out_reg == TIMER_W'(1)) begin
                state_next   = TMR_DONE;
                expired_next = 1'b1;
              end
            end
          end else begin
            state_next = TMR_ARMED;
          end
        end
        default: begin
          // IDLE and DONE hold 0 until a load
        end
      endcase
    end
  end

  assign timer_out     = out_reg;
  assign timer_expired = expired_reg;

endmodule

// File: tb/tb_traffic_interval_timer.sv
// Scoreboard bench for traffic_interval_timer: a seconds/fraction model
// predicts each cycle's outputs; a monitor compares them after every edge.
module tb_traffic_interval_timer;
  import traffic_interval_timer_pkg::*;

  localparam int TD = TICK_DIV_SIM;

  logic               clk;
  logic               rst;
  logic               timer_load;
  logic               timer_en;
  logic [TIMER_W-1:0] timer_init;
  logic [TIMER_W-1:0] timer_out;
  logic               timer_expired;
  logic               sec_tick;

  typedef struct {
    logic [3:0] out;
    logic       expired;
    logic       tick;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   m_rem  = 0;
  int   m_frac = 0;

  traffic_interval_timer #(.TICK_DIV(TD), .PS_W(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .timer_load    (timer_load),
    .timer_en      (timer_en),
    .timer_init    (timer_init),
    .timer_out     (timer_out),
    .timer_expired (timer_expired),
    .sec_tick      (sec_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: remaining seconds plus cycles elapsed in the current second.
  task automatic model_step(input logic l, input logic e, input int init);
    exp_t x;
    x.tick    = 1'b0;
    x.expired = 1'b0;
    if (l) begin
      m_rem  = init;
      m_frac = 0;
    end else if (e && m_rem > 0) begin
      m_frac++;
      if (m_frac == TD) begin
        m_frac    = 0;
        m_rem     = m_rem - 1;
        x.tick    = 1'b1;
        x.expired = (m_rem == 0);
      end
    end
    x.out = 4'(m_rem);
    sb.push_back(x);
  endtask

  task automatic cyc(input logic l, input logic e, input int init);
    @(negedge clk);
    timer_load = l;
    timer_en   = e;
    timer_init = 4'(init);
    model_step(l, e, init);
    $display("cycle load=%0b en=%0b init=%0d -> exp out=%0d", l, e, init, m_rem);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("timer_out", int'(timer_out), int'(mon_e.out));
      chk("timer_expired", int'(timer_expired), int'(mon_e.expired));
      chk("sec_tick", int'(sec_tick), int'(mon_e.tick));
    end
  end

  initial begin
    int first;
    rst        = 1'b0;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    timer_init = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", int'(timer_out), 0);
    chk("reset_expired", int'(timer_expired), 0);
    chk("reset_tick", int'(sec_tick), 0);
    @(negedge clk);
    rst = 1'b1;

    // Basic countdown with measured expiry latency
    cyc(1'b1, 1'b0, 5);
    first = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b0, 1'b1, 0);
      @(posedge clk);
      #2;
      if (timer_expired && first == 0) first = i;
    end
    chk("expiry_latency", first, 20);

    // Pause / resume
    cyc(1'b1, 1'b0, 3);
    repeat (6)  cyc(1'b0, 1'b1, 0);
    repeat (10) cyc(1'b0, 1'b0, 0);
    repeat (6)  cyc(1'b0, 1'b1, 0);

    // Reload mid-count at timer_out=4
    cyc(1'b1, 1'b0, 6);
    repeat (8)  cyc(1'b0, 1'b1, 0);
    cyc(1'b1, 1'b1, 10);
    repeat (45) cyc(1'b0, 1'b1, 0);

    // Load zero with enable high
    cyc(1'b1, 1'b1, 0);
    repeat (10) cyc(1'b0, 1'b1, 0);

    // Load coincident with the terminal tick
    cyc(1'b1, 1'b0, 1);
    repeat (3) cyc(1'b0, 1'b1, 0);
    cyc(1'b1, 1'b1, 9);
    repeat (8) cyc(1'b0, 1'b1, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 15)));
    end

    // Asynchronous reset mid-count at timer_out=7, then idle
    cyc(1'b1, 1'b0, 9);
    repeat (8) cyc(1'b0, 1'b1, 0);
    @(posedge clk);
    #2;
    chk("pre_reset_out", int'(timer_out), 7);
    rst = 1'b0;
    #1;
    chk("async_out", int'(timer_out), 0);
    chk("async_expired", int'(timer_expired), 0);
    chk("async_tick", int'(sec_tick), 0);
    m_rem  = 0;
    m_frac = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 100; i++) cyc(1'b0, ($urandom_range(0, 1) == 1), 0);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
